// File: rtl/mmc1_serial_loader.sv
// MMC1 serial port loader: collects five D0 bits written to cartridge ROM space
// and commits them as one 5-bit value to the register picked by the fifth write's address.
module mmc1_serial_loader #(
    parameter bit FILTER_CONSECUTIVE = 1'b1,
    parameter bit RESET_ON_D7        = 1'b1
) (
    input  logic       CPU_M2,
    input  logic       nRESET,
    input  logic       nCPU_ROMSEL,
    input  logic       nCPU_RW,
    input  logic       CPU_A14,
    input  logic       CPU_A13,
    input  logic       CPU_D0,
    input  logic       CPU_D7,
    output logic       oREG_WE,
    output logic [1:0] oREG_SEL,
    output logic [4:0] oREG_DATA,
    output logic       oCTRL_FIX,
    output logic [2:0] oSHIFT_CNT
);

    logic [2:0] count_r;
    logic [3:0] shift_r;
    logic       wr_prev_r;
    logic       reg_we_r;
    logic       ctrl_fix_r;
    logic [1:0] reg_sel_r;
    logic [4:0] reg_data_r;

    logic       wr_det_s;
    logic       accept_s;
    logic [2:0] count_s;
    logic [3:0] shift_s;
    logic       reg_we_s;
    logic       ctrl_fix_s;
    logic [1:0] reg_sel_s;
    logic [4:0] reg_data_s;

    // Write detection, consecutive-write filter and next-state of the shift sequence.
    always_comb begin
        wr_det_s   = (nCPU_ROMSEL == 1'b0) && (nCPU_RW == 1'b0);
        accept_s   = wr_det_s && ((FILTER_CONSECUTIVE == 1'b0) || (wr_prev_r == 1'b0));
        count_s    = count_r;
        shift_s    = shift_r;
        reg_we_s   = 1'b0;
        ctrl_fix_s = 1'b0;
        reg_sel_s  = reg_sel_r;
        reg_data_s = reg_data_r;
        if (accept_s) begin
            if ((RESET_ON_D7 == 1'b1) && (CPU_D7 == 1'b1)) begin
                count_s    = 3'd0;
                shift_s    = 4'd0;
                ctrl_fix_s = 1'b1;
            end else if (count_r >= 3'd4) begin
                // Fifth bit goes straight to the output; it is never stored in shift_r.
                reg_data_s = {CPU_D0, shift_r};
                reg_sel_s  = {CPU_A14, CPU_A13};
                reg_we_s   = 1'b1;
                count_s    = 3'd0;
                shift_s    = 4'd0;
            end else begin
                shift_s[count_r[1:0]] = CPU_D0;
                count_s               = count_r + 3'd1;
            end
        end else begin
            count_s = count_r;
        end
    end

    // State and output registers, updated on the falling edge of M2.
    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            count_r    <= 3'd0;
            shift_r    <= 4'd0;
            wr_prev_r  <= 1'b0;
            reg_we_r   <= 1'b0;
            ctrl_fix_r <= 1'b0;
            reg_sel_r  <= 2'd0;
            reg_data_r <= 5'd0;
        end else begin
            count_r    <= count_s;
            shift_r    <= shift_s;
            wr_prev_r  <= wr_det_s;
            reg_we_r   <= reg_we_s;
            ctrl_fix_r <= ctrl_fix_s;
            reg_sel_r  <= reg_sel_s;
            reg_data_r <= reg_data_s;
        end
    end

    assign oREG_WE    = reg_we_r;
    assign oREG_SEL   = reg_sel_r;
    assign oREG_DATA  = reg_data_r;
    assign oCTRL_FIX  = ctrl_fix_r;
    assign oSHIFT_CNT = count_r;

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Bench for mmc1_serial_loader: two instances (filter+D7 reset on / both off) checked
// every cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_mmc1_serial_loader;

    logic       CPU_M2;
    logic       nRESET;
    logic       nCPU_ROMSEL;
    logic       nCPU_RW;
    logic       CPU_A14;
    logic       CPU_A13;
    logic       CPU_D0;
    logic       CPU_D7;

    logic       a_we, b_we, a_fix, b_fix;
    logic [1:0] a_sel, b_sel;
    logic [4:0] a_data, b_data;
    logic [2:0] a_cnt, b_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, index 0 = filter and D7 reset enabled, index 1 = both disabled.
    bit prev_m[2];
    int nbits_m[2];
    int val_m[2];
    bit we_m[2];
    bit fix_m[2];
    int sel_m[2];
    int data_m[2];

    mmc1_serial_loader dut_a (
        .CPU_M2(CPU_M2), .nRESET(nRESET), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
        .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .oREG_WE(a_we), .oREG_SEL(a_sel), .oREG_DATA(a_data), .oCTRL_FIX(a_fix),
        .oSHIFT_CNT(a_cnt)
    );

    mmc1_serial_loader #(.FILTER_CONSECUTIVE(1'b0), .RESET_ON_D7(1'b0)) dut_b (
        .CPU_M2(CPU_M2), .nRESET(nRESET), .nCPU_ROMSEL(nCPU_ROMSEL), .nCPU_RW(nCPU_RW),
        .CPU_A14(CPU_A14), .CPU_A13(CPU_A13), .CPU_D0(CPU_D0), .CPU_D7(CPU_D7),
        .oREG_WE(b_we), .oREG_SEL(b_sel), .oREG_DATA(b_data), .oCTRL_FIX(b_fix),
        .oSHIFT_CNT(b_cnt)
    );

    initial begin
        CPU_M2 = 1'b1;
        forever #5 CPU_M2 = ~CPU_M2;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            prev_m[k] = 1'b0; nbits_m[k] = 0; val_m[k] = 0;
            we_m[k] = 1'b0; fix_m[k] = 1'b0; sel_m[k] = 0; data_m[k] = 0;
        end
    endtask

    // One falling edge of the model: bits accumulate as a number, LSB first.
    task automatic model_step();
        bit det, acc, filt, rd7;
        for (int k = 0; k < 2; k++) begin
            filt = (k == 0);
            rd7  = (k == 0);
            det  = (nCPU_ROMSEL == 1'b0) && (nCPU_RW == 1'b0);
            acc  = det && (!filt || !prev_m[k]);
            prev_m[k] = det;
            we_m[k]  = 1'b0;
            fix_m[k] = 1'b0;
            if (acc) begin
                if (rd7 && CPU_D7) begin
                    nbits_m[k] = 0; val_m[k] = 0; fix_m[k] = 1'b1;
                end else if (nbits_m[k] == 4) begin
                    data_m[k]  = val_m[k] + (CPU_D0 ? 16 : 0);
                    sel_m[k]   = (CPU_A14 ? 2 : 0) + (CPU_A13 ? 1 : 0);
                    we_m[k]    = 1'b1;
                    nbits_m[k] = 0; val_m[k] = 0;
                end else begin
                    val_m[k]   = val_m[k] + ((CPU_D0 ? 1 : 0) << nbits_m[k]);
                    nbits_m[k] = nbits_m[k] + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("a_we",   a_we,   we_m[0]);   chk("b_we",   b_we,   we_m[1]);
        chk("a_fix",  a_fix,  fix_m[0]);  chk("b_fix",  b_fix,  fix_m[1]);
        chk("a_sel",  a_sel,  sel_m[0]);  chk("b_sel",  b_sel,  sel_m[1]);
        chk("a_data", a_data, data_m[0]); chk("b_data", b_data, data_m[1]);
        chk("a_cnt",  a_cnt,  nbits_m[0]); chk("b_cnt", b_cnt,  nbits_m[1]);
    endtask

    // Inputs change just after the rising edge, state moves on the falling edge,
    // outputs are compared just after the following rising edge.
    task automatic cyc(input bit romsel_n, input bit rw_n, input bit a14, input bit a13,
                       input bit d0, input bit d7);
        nCPU_ROMSEL = romsel_n; nCPU_RW = rw_n;
        CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
        @(negedge CPU_M2);
        model_step();
        @(posedge CPU_M2);
        #1;
        compare_all();
    endtask

    task automatic wr(input bit a14, input bit a13, input bit d0, input bit d7);
        cyc(1'b0, 1'b0, a14, a13, d0, d7);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_iso(input bit a14, input bit a13, input bit d0, input bit d7);
        wr(a14, a13, d0, d7);
        idle();
    endtask

    // Reset asserted while M2 is high, checked immediately, released before the falling edge.
    task automatic pulse_reset();
        nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
        #1 nRESET = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_a_cnt", a_cnt, 8'd0);
        chk("rst_a_data", a_data, 8'd0);
        chk("rst_a_sel", a_sel, 8'd0);
        chk("rst_b_cnt", b_cnt, 8'd0);
        #1 nRESET = 1'b1;
        idle();
    endtask

    initial begin
        bit [4:0] d030;
        nRESET = 1'b0;
        nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
        CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D0 = 1'b0; CPU_D7 = 1'b0;
        model_reset();
        @(posedge CPU_M2);
        #1;
        compare_all();
        chk("init_a_we", a_we, 8'd0);
        chk("init_a_data", a_data, 8'd0);
        nRESET = 1'b1;
        idle();

        // Five isolated writes at $E000, D0 = 1,0,1,1,0.
        d030 = 5'b01101;
        for (int i = 0; i < 4; i++) wr_iso(1'b1, 1'b1, d030[i], 1'b0);
        wr(1'b1, 1'b1, d030[4], 1'b0);
        chk("e030_we", a_we, 8'd1);
        chk("e030_data", a_data, 8'h0D);
        chk("e030_sel", a_sel, 8'd3);
        chk("e030_model_data", data_m[0], 8'h0D);
        chk("e030_b_data", b_data, 8'h0D);
        idle();
        chk("e030_we_drop", a_we, 8'd0);
        chk("e030_hold", a_data, 8'h0D);

        // Three bits to $8000, then a D7 reset, then five zeros to $A000.
        for (int i = 0; i < 3; i++) wr_iso(1'b0, 1'b0, 1'b1, 1'b0);
        wr(1'b0, 1'b0, 1'b0, 1'b1);
        chk("e031_fix", a_fix, 8'd1);
        chk("e031_cnt", a_cnt, 8'd0);
        chk("e031_we", a_we, 8'd0);
        chk("e031_b_cnt", b_cnt, 8'd4);
        idle();
        chk("e031_fix_drop", a_fix, 8'd0);
        for (int i = 0; i < 5; i++) wr_iso(1'b0, 1'b1, 1'b0, 1'b0);
        chk("e031_data", a_data, 8'd0);
        chk("e031_sel", a_sel, 8'd1);
        chk("e031_b_data", b_data, 8'h07);

        // Read-modify-write pair: back-to-back D0 = 1 then 0.
        pulse_reset();
        wr(1'b0, 1'b0, 1'b1, 1'b0);
        wr(1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("e032_a_cnt", a_cnt, 8'd1);
        chk("e032_b_cnt", b_cnt, 8'd2);

        // D7 on a filtered write is ignored.
        wr(1'b0, 1'b0, 1'b0, 1'b0);
        wr(1'b0, 1'b0, 1'b0, 1'b1);
        chk("e027_fix", a_fix, 8'd0);
        chk("e027_cnt", a_cnt, 8'd2);
        idle();

        // Reset after three bits, then five ones to $C000.
        pulse_reset();
        for (int i = 0; i < 3; i++) wr_iso(1'b1, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        for (int i = 0; i < 5; i++) wr_iso(1'b1, 1'b0, 1'b1, 1'b0);
        chk("e033_data", a_data, 8'h1F);
        chk("e033_sel", a_sel, 8'd2);
        chk("e033_b_data", b_data, 8'h1F);

        // ROMSEL-high writes interleaved into a sequence.
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 1'b1, 1'b1, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("e034_cnt", a_cnt, 8'(i + 1));
            chk("e034_we", a_we, 8'd0);
        end
        wr(1'b1, 1'b1, 1'b0, 1'b0);
        chk("e034_commit", a_we, 8'd1);
        chk("e034_data", a_data, 8'h0F);
        chk("e034_sel", a_sel, 8'd3);
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmc1_serial_loader.md
MMC1_SERIAL_LOADER -- requirements
Module: mmc1_serial_loader

Interface
REQ-001 SHALL have parameter FILTER_CONSECUTIVE, default 1; 1 = ignore a write on the M2 cycle directly after a detected write, 0 = accept every write.
REQ-002 SHALL have parameter RESET_ON_D7, default 1; 1 = a write with D7 high clears the shift sequence, 0 = D7 is ignored.
REQ-003 SHALL have port CPU_M2  input  1  single clock; all state updates on its falling edge.
REQ-004 SHALL have port nRESET  input  1  asynchronous active-low reset.
REQ-005 SHALL have port nCPU_ROMSEL  input  1  cartridge ROM space select, active low.
REQ-006 SHALL have port nCPU_RW  input  1  CPU read/write; low = write.
REQ-007 SHALL have port CPU_A14  input  1  register select bit 1.
REQ-008 SHALL have port CPU_A13  input  1  register select bit 0.
REQ-009 SHALL have port CPU_D0  input  1  serial data bit.
REQ-010 SHALL have port CPU_D7  input  1  sequence reset request.
REQ-011 SHALL have port oREG_WE  output  1  one-cycle commit strobe to the MMC1 register file.
REQ-012 SHALL have port oREG_SEL  output  2  target register: 00 control, 01 CHR0, 10 CHR1, 11 PRG.
REQ-013 SHALL have port oREG_DATA  output  5  assembled 5-bit value; valid while oREG_WE = 1, held afterwards.
REQ-014 SHALL have port oCTRL_FIX  output  1  one-cycle strobe telling the register file to OR 5'b01100 into control.
REQ-015 SHALL have port oSHIFT_CNT  output  3  number of bits collected so far, 0..4.

Function
REQ-016 A write SHALL be detected on a falling CPU_M2 edge when nCPU_ROMSEL = 0 and nCPU_RW = 0.
REQ-017 A flag wr_prev SHALL record whether a write was detected on the previous falling edge, whether or not that write was accepted.
REQ-018 With FILTER_CONSECUTIVE = 1, a detected write SHALL be accepted only if wr_prev = 0; a run of N back-to-back writes SHALL accept only the first.
REQ-019 An accepted write with CPU_D7 = 1 and RESET_ON_D7 = 1 SHALL set the count to 0, clear the shift register, and pulse oCTRL_FIX for exactly one cycle, with oREG_WE = 0.
REQ-020 An accepted write with CPU_D7 = 0 and count < 4 SHALL store CPU_D0 into shift bit [count] (LSB first) and increment the count.
REQ-021 An accepted write with CPU_D7 = 0 and count = 4 SHALL, on that edge, drive oREG_DATA = {CPU_D0, shift[3:0]}, drive oREG_SEL = {CPU_A14, CPU_A13} of this fifth write, pulse oREG_WE for one cycle, and set the count and shift register to 0.
REQ-022 Address bits on writes 1-4 SHALL be ignored; only the fifth write selects the register.
REQ-023 All outputs SHALL be registered; latency from the accepted write edge to the strobe is 0 cycles (the strobe is visible after that edge and lasts until the next falling edge).
REQ-024 oREG_WE and oCTRL_FIX SHALL never both be 1.
REQ-025 oREG_DATA and oREG_SEL SHALL hold their last committed value until the next commit.
REQ-026 Reads (nCPU_RW = 1) or cycles with nCPU_ROMSEL = 1 SHALL leave the count and shift register unchanged and clear wr_prev.
REQ-027 A D7 reset on a filtered (consecutive) write SHALL be ignored like any filtered write.

Reset
REQ-028 When nRESET = 0, the following SHALL be cleared immediately, independent of CPU_M2: count = 0, shift = 0, wr_prev = 0, oREG_WE = 0, oCTRL_FIX = 0, oREG_SEL = 00, oREG_DATA = 00000.
REQ-029 A sequence that is partly collected when reset asserts SHALL be discarded; the first accepted write after release SHALL be bit 0.

Verification
REQ-030 Five isolated writes at $E000 with D0 = 1,0,1,1,0 -> one oREG_WE pulse on the fifth edge, oREG_SEL = 11, oREG_DATA = 01101.
REQ-031 Three writes with D0 = 1 to $8000, then a write with D7 = 1 -> oCTRL_FIX pulse, oSHIFT_CNT = 0; the next five writes of 0 to $A000 -> oREG_DATA = 00000, oREG_SEL = 01.
REQ-032 A read-modify-write pair (two back-to-back writes with D0 = 1 then D0 = 0) with filter on -> only the 1 is shifted, oSHIFT_CNT = 1; with filter off -> oSHIFT_CNT = 2.
REQ-033 nRESET pulsed low mid-cycle after 3 bits -> all outputs 0 at once; five later writes to $C000 with D0 = 1 -> oREG_DATA = 11111, oREG_SEL = 10.
REQ-034 Writes with nCPU_ROMSEL = 1 interleaved into a sequence -> no change to oSHIFT_CNT; the commit occurs only on the fifth valid write.
